// File: rtl/cal_gy_pkg.sv
// Shared constants, FSM state type and int16 saturation helper for the
// float32 deg/s -> raw gyro code converter (cal_gy_f2i).
package cal_gy_pkg;

    localparam int          FLT_BIAS  = 127;
    localparam int          FLT_MAN_W = 23;
    localparam int          FRAC_BITS = 12;
    localparam logic [16:0] SCALE_Q   = 17'd67109;  // round(16.384 * 2^FRAC_BITS)
    localparam logic [15:0] INT16_MAX = 16'h7FFF;
    localparam logic [15:0] INT16_MIN = 16'h8000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPK,
        ST_MUL,
        ST_SHIFT,
        ST_SAT,
        ST_OFS
    } state_t;

    typedef struct packed {
        logic [15:0] val;
        logic        clip;
    } sat16_t;

    // Clamp a 17-bit two's-complement value into int16.
    function automatic sat16_t sat16(input logic [16:0] v);
        sat16_t r;
        if (v[16] != v[15]) begin
            r.val  = v[16] ? INT16_MIN : INT16_MAX;
            r.clip = 1'b1;
        end else begin
            r.val  = v[15:0];
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/f2i_round_shift.sv
// Right shift of the 41-bit scaled product by sh with round-half-away-from-zero;
// sh <= 0 means the value cannot fit and raises ovf.
module f2i_round_shift (
    input  logic [40:0]       p,
    input  logic signed [9:0] sh,
    output logic [25:0]       mag,
    output logic              ovf
);

    logic [5:0]  amt;
    logic [40:0] shifted;
    logic [41:0] sum;

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        mag     = '0;
        ovf     = 1'b0;
        amt     = sh[5:0];
        shifted = p >> amt;
        sum     = {1'b0, shifted} + {41'd0, p[amt - 6'd1]};
        if (sh <= 10'sd0) begin
            ovf = 1'b1;
        end else if (sh <= 10'sd41) begin
            mag = sum[25:0];
            ovf = |sum[41:26];
        end
    end

endmodule

// File: rtl/cal_gy_f2i.sv
// float32 angular rate (deg/s) -> int16 raw gyro code, raw = round(rate*16.384).
// Define CAL_GY_F2I_OFFSET_EN to add the gy_offset port and the OFS stage.
module cal_gy_f2i
    import cal_gy_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] f_in,
`ifdef CAL_GY_F2I_OFFSET_EN
    input  logic [15:0] gy_offset,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] gy_raw,
    output logic        sat,
    output logic        nan
);

    state_t state, state_nxt;

    logic [31:0]       f_q;
    logic              s_q, nan_q, inf_q, ovf_q;
    logic [7:0]        e_q;
    logic [23:0]       m_q;
    logic [40:0]       p_q;
    logic [25:0]       mag_q;
    logic signed [9:0] sh;
    logic [25:0]       rs_mag;
    logic              rs_ovf;
    logic [15:0]       res;
    logic              res_sat, res_nan;

    // NOTE: state and outputs use <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_UNPK;
            ST_UNPK:  state_nxt = ST_MUL;
            ST_MUL:   state_nxt = ST_SHIFT;
            ST_SHIFT: state_nxt = ST_SAT;
`ifdef CAL_GY_F2I_OFFSET_EN
            ST_SAT:   state_nxt = ST_OFS;
`else
            ST_SAT:   state_nxt = ST_IDLE;
`endif
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign sh   = 10'(FLT_MAN_W + FRAC_BITS + FLT_BIAS) - {2'b00, e_q};

    f2i_round_shift u_round_shift (
        .p   (p_q),
        .sh  (sh),
        .mag (rs_mag),
        .ovf (rs_ovf)
    );

    always_comb begin
        res     = s_q ? (16'd0 - mag_q[15:0]) : mag_q[15:0];
        res_sat = 1'b0;
        res_nan = 1'b0;
        if (nan_q) begin
            res     = '0;
            res_nan = 1'b1;
        end else if (inf_q || ovf_q
                     || (!s_q && mag_q > 26'd32767)
                     || ( s_q && mag_q > 26'd32768)) begin
            res     = s_q ? INT16_MIN : INT16_MAX;
            res_sat = 1'b1;
        end
    end

`ifdef CAL_GY_F2I_OFFSET_EN
    logic [15:0] conv_q;
    logic        conv_sat_q, conv_nan_q;
    sat16_t      ofs_res;

    always_comb ofs_res = sat16({conv_q[15], conv_q} + {gy_offset[15], gy_offset});
`endif

    // NOTE: datapath registers have no reset; each is rewritten before it is read.
    // f_in is captured raw at acceptance; field decode happens in UNPK.
    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: if (start) f_q <= f_in;
            ST_UNPK: begin
                s_q   <= f_q[31];
                e_q   <= f_q[30:23];
                m_q   <= (f_q[30:23] == 8'd0) ? 24'd0 : {1'b1, f_q[22:0]};
                nan_q <= (&f_q[30:23]) &&  (|f_q[22:0]);
                inf_q <= (&f_q[30:23]) && !(|f_q[22:0]);
            end
            ST_MUL:  p_q <= {17'd0, m_q} * {24'd0, SCALE_Q};
            ST_SHIFT: begin
                mag_q <= rs_mag;
                ovf_q <= rs_ovf;
            end
`ifdef CAL_GY_F2I_OFFSET_EN
            ST_SAT: begin
                conv_q     <= res;
                conv_sat_q <= res_sat;
                conv_nan_q <= res_nan;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            done   <= 1'b0;
            gy_raw <= '0;
            sat    <= 1'b0;
            nan    <= 1'b0;
        end else begin
            done <= 1'b0;
`ifdef CAL_GY_F2I_OFFSET_EN
            if (state == ST_OFS) begin
                gy_raw <= conv_nan_q ? 16'd0 : ofs_res.val;
                sat    <= !conv_nan_q && (conv_sat_q || ofs_res.clip);
                nan    <= conv_nan_q;
                done   <= 1'b1;
            end
`else
            if (state == ST_SAT) begin
                gy_raw <= res;
                sat    <= res_sat;
                nan    <= res_nan;
                done   <= 1'b1;
            end
`endif
        end
    end

endmodule
